// File: rtl/icache_refill_ctrl_if.sv
// Fetch, memory-read and cache-install signals of the instruction-cache refill engine.
// master = refill controller, slave = pipeline/memory/cache environment.
interface icache_refill_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 fetch_valid;
  logic [31:0]          addr;
  logic                 hit_miss;
  logic                 mem_rd;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_rdata;
  logic                 mem_ack;
  logic [63:0]          din_mem;
  logic                 countdone;
  logic                 stall;
  logic                 mem_timeout;
  logic [CNT_WIDTH-1:0] refill_count;

  modport master (
    input  fetch_valid, addr, hit_miss, mem_rdata, mem_ack,
    output mem_rd, mem_addr, din_mem, countdone, stall, mem_timeout, refill_count
  );

  modport slave (
    output fetch_valid, addr, hit_miss, mem_rdata, mem_ack,
    input  mem_rd, mem_addr, din_mem, countdone, stall, mem_timeout, refill_count
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Refill engine for a direct-mapped I-cache: two-beat 64-bit block fetch, install pulse, settle.
// Optional macro ICACHE_CWF_EN fetches the addressed word first (critical-word-first).
module icache_refill_ctrl #(
  parameter int TIMEOUT    = 64,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  icache_refill_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, DONE, SETTLE} state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + SETTLE_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYC - 1);

  state_t               state_q, state_d;
  logic [28:0]          blk_q, blk_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [63:0]          din_mem_q, din_mem_d;
  logic [CNT_WIDTH-1:0] refill_count_q, refill_count_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic                 crit_hi_q, crit_hi_d;

  logic        miss;
  logic        blk_match;
  logic        beat_hi;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        countdone;
  logic        stall;
  logic        unused_addr_bits;

  assign miss             = bus.fetch_valid & ~bus.hit_miss;
  assign blk_match        = (bus.addr[31:3] == blk_q);
  assign unused_addr_bits = ^bus.addr[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      blk_q          <= '0;
      wait_q         <= '0;
      din_mem_q      <= '0;
      refill_count_q <= '0;
      mem_timeout_q  <= 1'b0;
      crit_hi_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      wait_q         <= wait_d;
      din_mem_q      <= din_mem_d;
      refill_count_q <= refill_count_d;
      mem_timeout_q  <= mem_timeout_d;
      crit_hi_q      <= crit_hi_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    blk_d          = blk_q;
    wait_d         = wait_q;
    din_mem_d      = din_mem_q;
    refill_count_d = refill_count_q;
    mem_timeout_d  = mem_timeout_q;
    crit_hi_d      = crit_hi_q;
    mem_rd         = 1'b0;
    mem_addr       = '0;
    countdone      = 1'b0;
    stall          = 1'b0;
    beat_hi        = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        stall = miss & ~rst;
        if (miss) begin
          blk_d   = bus.addr[31:3];
          wait_d  = '0;
          state_d = RD0;
`ifdef ICACHE_CWF_EN
          crit_hi_d = bus.addr[2];
`else
          crit_hi_d = 1'b0;
`endif
        end
      end

      RD0, RD1: begin
        stall    = 1'b1;
        mem_rd   = 1'b1;
        beat_hi  = (state_q == RD0) ? crit_hi_q : ~crit_hi_q;
        mem_addr = {blk_q, beat_hi, 2'b00};
        if (bus.mem_ack) begin
          if (beat_hi) din_mem_d[63:32] = bus.mem_rdata;
          else         din_mem_d[31:0]  = bus.mem_rdata;
          wait_d  = '0;
          state_d = (state_q == RD0) ? RD1 : DONE;
        end else if (wait_q == WAIT_LAST) begin
          mem_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      DONE: begin
        // A changed fetch address means the pipeline moved on; drop the block silently.
        stall  = 1'b1;
        wait_d = '0;
        if (blk_match) begin
          countdone = 1'b1;
          if (refill_count_q != '1) refill_count_d = refill_count_q + CNT_WIDTH'(1);
        end
        state_d = SETTLE;
      end

      SETTLE: begin
        // The cache hit flag is registered, so it lags the install by one edge.
        stall = 1'b1;
        if (wait_q == SETTLE_LAST) begin
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd       = mem_rd;
  assign bus.mem_addr     = mem_addr;
  assign bus.countdone    = countdone;
  assign bus.stall        = stall;
  assign bus.din_mem      = din_mem_q;
  assign bus.mem_timeout  = mem_timeout_q;
  assign bus.refill_count = refill_count_q;

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Refill engine directly upstream of the direct-mapped instruction cache.
- On a fetch miss it stalls the pipeline and reads the missing 64-bit block from a 32-bit word memory in two beats.
- It drives the assembled block on din_mem and pulses countdone so the cache installs data, tag and valid.
- It then waits out the cache's registered hit/miss latency before releasing the stall.

Parameters:
TIMEOUT, 64, max cycles to wait for mem_ack on one beat before aborting
SETTLE_CYC, 2, cycles after countdone during which hit_miss is ignored and stall is held
CNT_WIDTH, 16, width of the refill performance counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
fetch_valid  input  1  pipeline presents a valid fetch addr this cycle
addr  input  32  fetch address, same bus the cache sees
hit_miss  input  1  registered cache hit flag (1 = hit)
mem_rd  output  1  word read request, held until mem_ack
mem_addr  output  32  word-aligned read address
mem_rdata  input  32  read data, valid when mem_ack=1
mem_ack  input  1  one-cycle data-valid/accept from memory
din_mem  output  64  assembled block to cache (word0 in [31:0], word1 in [63:32])
countdone  output  1  one-cycle pulse: din_mem complete, cache must install block
stall  output  1  freeze fetch; pipeline holds addr stable while 1
mem_timeout  output  1  sticky error flag, set on beat timeout
refill_count  output  CNT_WIDTH  completed refills, saturating

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, din_mem=0, blk=0, wait counter=0.
- The FSM has five states: IDLE, RD0, RD1, DONE, SETTLE.
- IDLE:
  - stall = fetch_valid & ~hit_miss (combinational).
  - If fetch_valid & ~hit_miss: capture blk=addr[31:3], clear wait counter, next state RD0.
- RD0 (stall=1):
  - mem_rd=1, mem_addr={blk,3'b000}.
  - On mem_ack: din_mem[31:0]<=mem_rdata, counter cleared, next state RD1.
- RD1 (stall=1):
  - mem_rd=1, mem_addr={blk,3'b100}.
  - On mem_ack: din_mem[63:32]<=mem_rdata, next state DONE.
- mem_rd and mem_addr are stable for the whole beat. Exactly one request is outstanding. An ack in the same cycle the beat starts is accepted.
- Timeout:
  - The counter increments every RD0/RD1 cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: mem_timeout<=1 (sticky until rst), mem_rd drops, next state IDLE, no countdone.
- DONE (stall=1, one cycle):
  - If addr[31:3]==blk: countdone=1 and refill_count increments, saturating at all-ones.
  - Otherwise the refill is silently discarded: countdone=0, counter unchanged.
  - Next state SETTLE.
- SETTLE (stall=1): lasts SETTLE_CYC cycles; hit_miss is ignored; then next state IDLE.
  - Reason: the cache installs at the end of the DONE cycle and its hit flag updates one edge later.
- din_mem holds its last value outside refills and is never cleared except by rst.
- mem_ack outside RD0/RD1 is ignored.
- fetch_valid=0 in IDLE leaves the FSM idle even if hit_miss=0.
- rst asserted mid-refill: immediate return to IDLE with all outputs 0. A memory read already in flight is abandoned; its late ack is ignored.

Optional Feature:
ICACHE_CWF_EN: critical-word-first.
- Defined: if the captured addr[2]=1, RD0 fetches {blk,3'b100} into [63:32] and RD1 fetches {blk,3'b000} into [31:0]. Otherwise the order is the same as without the macro. din_mem is identical at countdone either way.
- Undefined: word0 is always fetched first.

Test Plan:
- rst pulse mid-RD1 -> stall=0, mem_rd=0, countdone=0, mem_timeout=0 within the same cycle (async); next miss restarts at RD0.
- fetch_valid=1, addr=0x0000_2008, hit_miss=0; ack 3 cycles after each request with 0xAAAA_0001 then 0xBBBB_0002 -> mem_addr 0x2008 then 0x200C; DONE cycle has din_mem=0xBBBB_0002_AAAA_0001 and countdone=1 for exactly one cycle; stall held through SETTLE (2 cycles); refill_count=1.
- Same miss, addr changed to 0x0000_4000 before DONE -> countdone stays 0, refill_count unchanged, FSM passes through SETTLE to IDLE.
- Miss with mem_ack never asserted, TIMEOUT=64 -> after 64 RD0 cycles mem_timeout=1, mem_rd=0, state IDLE; mem_timeout stays 1 until rst.
- ICACHE_CWF_EN defined, addr=0x0000_300C miss -> first mem_addr 0x300C, second 0x3008; final din_mem places 0x300C data in [63:32].
- hit_miss=1 with fetch_valid=1 in IDLE for 10 cycles -> stall=0, mem_rd=0 throughout.
